izigzag_seq: RTL

Sequencer for the inverse-zigzag stage of the JPEG decoder. It collects serial dequantised coefficients (zigzag order, 32-bit) from the upstream stage into a 64-entry block bus and drives the `izigzag` register stage. It waits out that stage's fixed latency, then captures the raster-ordered block. It presents the captured block to the IDCT with a valid/ready handshake. Filling of the next block overlaps output of the current one.

---
 rtl/jpeg_pkg.sv | 14 +
 rtl/izz_out_slot.sv | 55 +++++
 rtl/izigzag_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG decoder definitions: block size, coefficient index width and
// the fill-state encoding used by the inverse-zigzag sequencer.
package jpeg_pkg;

  localparam int BLK_N = 64;
  localparam int IDX_W = $clog2(BLK_N);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_LAUNCH = 2'd1,
    S_XFER   = 2'd2
  } izz_seq_state_t;

endpackage

// File: rtl/izz_out_slot.sv
// Single-entry valid/ready output register holding one raster block, plus
// the modulo-2^CNTW counter of blocks delivered downstream.
module izz_out_slot
  import jpeg_pkg::*;
#(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cap_i,
  input  logic [BLK_N*DW-1:0] cap_data_i,
  input  logic                blk_ready_i,
  output logic                blk_valid_o,
  output logic [BLK_N*DW-1:0] blk_data_o,
  output logic [CNTW-1:0]     blk_count_o
);

  logic                valid_q, valid_d;
  logic [BLK_N*DW-1:0] data_q, data_d;
  logic [CNTW-1:0]     count_q, count_d;

  // A capture in the same cycle as a transfer refills the slot, so valid
  // stays high while the count still advances.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (valid_q && blk_ready_i) begin
      valid_d = 1'b0;
      count_d = count_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
    if (cap_i) begin
      valid_d = 1'b1;
      data_d  = cap_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign blk_valid_o = valid_q;
  assign blk_data_o  = data_q;
  assign blk_count_o = count_q;

endmodule

// File: rtl/izigzag_seq.sv
// Inverse-zigzag sequencer: fills a 64-slot zigzag block, waits out the
// external izigzag latency, then hands the raster block to the IDCT.
// Optional early end-of-block input enabled by defining IZZ_SEQ_EOB_EN.
module izigzag_seq
  import jpeg_pkg::*;
#(
  parameter int DW   = 32,
  parameter int LAT  = 1,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coef_valid,
  output logic                coef_ready,
  input  logic [DW-1:0]       coef_data,
`ifdef IZZ_SEQ_EOB_EN
  input  logic                coef_eob,
`endif
  output logic [BLK_N*DW-1:0] zz_data,
  input  logic [BLK_N*DW-1:0] izz_data,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [BLK_N*DW-1:0] blk_data,
  output logic                busy,
  output logic [CNTW-1:0]     blk_count,
  output logic [1:0]          dbg_state
);

  localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;

  izz_seq_state_t      state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WCW-1:0]      wait_q, wait_d;
  logic [BLK_N*DW-1:0] zz_q, zz_d;
  logic                eob;
  logic                capture;

`ifdef IZZ_SEQ_EOB_EN
  assign eob = coef_eob;
`else
  assign eob = 1'b0;
`endif

  // Handshakes on both sides: a word/block moves on a clock edge where
  // valid && ready; the source holds its data until that edge.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wait_d     = wait_q;
    zz_d       = zz_q;
    coef_ready = 1'b0;
    capture    = 1'b0;
    case (state_q)
      S_FILL: begin
        coef_ready = 1'b1;
        if (coef_valid) begin
          zz_d[idx_q*DW +: DW] = coef_data;
          idx_d                = idx_q + 1'b1;
          if (idx_q == IDX_W'(BLK_N - 1) || eob) begin
            state_d = S_LAUNCH;
            wait_d  = WCW'(LAT - 1);
          end
        end
      end
      S_LAUNCH: begin
        if (wait_q == '0) state_d = S_XFER;
        else              wait_d  = wait_q - 1'b1;
      end
      S_XFER: begin
        // Clearing zz here leaves unwritten slots zero after an early EOB.
        if (!blk_valid || blk_ready) begin
          capture = 1'b1;
          zz_d    = '0;
          idx_d   = '0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      wait_q  <= '0;
      zz_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      zz_q    <= zz_d;
    end
  end

  izz_out_slot #(
    .DW   (DW),
    .CNTW (CNTW)
  ) u_out_slot (
    .clk_i       (clk),
    .rst_ni      (rst),
    .cap_i       (capture),
    .cap_data_i  (izz_data),
    .blk_ready_i (blk_ready),
    .blk_valid_o (blk_valid),
    .blk_data_o  (blk_data),
    .blk_count_o (blk_count)
  );

  assign zz_data   = zz_q;
  assign busy      = (state_q != S_FILL) || (idx_q != '0) || blk_valid;
  assign dbg_state = state_q;

endmodule
